// File: rtl/d_cache_ctrl_pkg.sv
// Shared constants for the L1 data cache controller: default timing, address
// field widths, FSM state encoding and a saturating counter helper.
package d_cache_ctrl_pkg;

  localparam int DEF_MEM_LATENCY = 2;
  localparam int DEF_WORD_W      = 16;
  localparam int OFFSET_W        = 2;
  localparam int INDEX_W         = 2;
  localparam int TAG_W           = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/d_cache_array.sv
// Valid/tag/data storage for the direct-mapped cache: one async read port,
// a full-line fill port and a single-word write port.
module d_cache_array
  import d_cache_ctrl_pkg::*;
#(
  parameter int WORD_W         = DEF_WORD_W,
  parameter int NUM_LINES      = 1 << INDEX_W,
  parameter int WORDS_PER_LINE = 1 << OFFSET_W,
  parameter int TAG_BITS       = TAG_W
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [$clog2(NUM_LINES)-1:0]       rd_index,
  output logic                               rd_valid,
  output logic [TAG_BITS-1:0]                rd_tag,
  output logic [WORD_W*WORDS_PER_LINE-1:0]   rd_line,
  input  logic                               fill_en,
  input  logic [$clog2(NUM_LINES)-1:0]       fill_index,
  input  logic [TAG_BITS-1:0]                fill_tag,
  input  logic [WORD_W*WORDS_PER_LINE-1:0]   fill_line,
  input  logic                               wr_en,
  input  logic [$clog2(NUM_LINES)-1:0]       wr_index,
  input  logic [$clog2(WORDS_PER_LINE)-1:0]  wr_offset,
  input  logic [WORD_W-1:0]                  wr_data
);

  localparam int LINE_W = WORD_W * WORDS_PER_LINE;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] valid_d;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

  always_comb begin
    valid_d = valid_q;
    if (fill_en) valid_d[fill_index] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) valid_q <= '0;
    else          valid_q <= valid_d;
  end

  // Tag and data contents survive reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= fill_line;
    end
    if (wr_en) data_q[wr_index][int'(wr_offset)*WORD_W +: WORD_W] <= wr_data;
  end

endmodule

// File: rtl/d_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache controller
// with zero-cycle read hits and fixed-latency block fills / word writes.
module d_cache_ctrl
  import d_cache_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY    = DEF_MEM_LATENCY,
  parameter int WORD_W         = DEF_WORD_W,
  parameter int NUM_LINES      = 1 << INDEX_W,
  parameter int WORDS_PER_LINE = 1 << OFFSET_W
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              d_read_req,
  input  logic                              d_write_req,
  input  logic [WORD_W-1:0]                 d_addr,
  input  logic [WORD_W-1:0]                 d_wdata,
  output logic [WORD_W-1:0]                 d_rdata,
  output logic                              d_read_ready,
  output logic                              d_write_done,
  output logic                              mem_read,
  output logic                              mem_write,
  output logic [WORD_W-1:0]                 mem_addr,
  output logic [WORD_W-1:0]                 mem_wdata,
  input  logic [WORD_W*WORDS_PER_LINE-1:0]  mem_rblock,
  output logic [15:0]                       hit_count,
  output logic [15:0]                       miss_count
);

  localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS = WORD_W - OFF_BITS - IDX_BITS;
  localparam int LINE_W   = WORD_W * WORDS_PER_LINE;
  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [WORD_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [15:0]         hit_q, hit_d;
  logic [15:0]         miss_q, miss_d;

  logic [TAG_BITS-1:0] req_tag;
  logic [IDX_BITS-1:0] req_index;
  logic [OFF_BITS-1:0] req_offset;
  logic                rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [LINE_W-1:0]   rd_line;
  logic                hit;
  logic                done;
  logic                fill_en;
  logic                wr_en;

  assign req_tag    = d_addr[WORD_W-1 -: TAG_BITS];
  assign req_index  = d_addr[OFF_BITS +: IDX_BITS];
  assign req_offset = d_addr[OFF_BITS-1:0];
  assign hit        = rd_valid && (rd_tag == req_tag);
  assign done       = ({1'b0, cnt_q} + 3'd1) == LAT;

  d_cache_array #(
    .WORD_W         (WORD_W),
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TAG_BITS       (TAG_BITS)
  ) u_array (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_index   (req_index),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_line    (rd_line),
    .fill_en    (fill_en),
    .fill_index (addr_q[OFF_BITS +: IDX_BITS]),
    .fill_tag   (addr_q[WORD_W-1 -: TAG_BITS]),
    .fill_line  (mem_rblock),
    .wr_en      (wr_en),
    .wr_index   (req_index),
    .wr_offset  (req_offset),
    .wr_data    (d_wdata)
  );

  // The request address and store data are latched on entry so that a
  // transaction runs to completion even if the pipeline drops its request.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    d_rdata      = '0;
    d_read_ready = 1'b0;
    d_write_done = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    fill_en      = 1'b0;
    wr_en        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (d_write_req) begin
          addr_d  = d_addr;
          wdata_d = d_wdata;
          wr_en   = hit;
          state_d = WR_THRU;
        end else if (d_read_req) begin
          if (hit) begin
            d_read_ready = 1'b1;
            d_rdata      = rd_line[int'(req_offset)*WORD_W +: WORD_W];
            hit_d        = sat_inc16(hit_q);
          end else begin
            addr_d  = d_addr;
            miss_d  = sat_inc16(miss_q);
            state_d = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        mem_read = 1'b1;
        mem_addr = {addr_q[WORD_W-1:OFF_BITS], {OFF_BITS{1'b0}}};
        if (done) begin
          fill_en = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WR_THRU: begin
        mem_write = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (done) begin
          d_write_done = 1'b1;
          cnt_d        = '0;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_d_cache_ctrl.sv
// Directed self-checking bench for d_cache_ctrl: read miss/hit, write-through
// hit and miss, conflict eviction and asynchronous reset mid-fill.
module tb_d_cache_ctrl;

  logic        clk;
  logic        reset_n;
  logic        d_read_req;
  logic        d_write_req;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_read_ready;
  logic        d_write_done;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [63:0] mem_rblock;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int checks;
  int errors;
  int exp_hits;

  d_cache_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .d_read_req   (d_read_req),
    .d_write_req  (d_write_req),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_read_ready (d_read_ready),
    .d_write_done (d_write_done),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rblock   (mem_rblock),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [15:0] wdata);
    d_read_req  = rd;
    d_write_req = wr;
    d_addr      = addr;
    d_wdata     = wdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readMiss(input logic [15:0] addr, input logic [63:0] block,
                          input logic [15:0] exp_word, input logic [15:0] exp_miss);
    int  n;
    bit  seen;
    mem_rblock = block;
    applyStimulus(1'b1, 1'b0, addr, 16'h0);
    checkOutput("miss_idle_ready", d_read_ready, 0);
    checkOutput("miss_idle_memrd", mem_read, 0);
    n    = 0;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (d_read_ready) seen = 1;
      else if (mem_read) begin
        n++;
        checkOutput("miss_mem_addr", mem_addr, {addr[15:2], 2'b00});
        checkOutput("miss_no_write", mem_write, 0);
      end
    end
    checkOutput("miss_latency", n, 2);
    checkOutput("miss_ready", d_read_ready, 1);
    checkOutput("miss_rdata", d_rdata, exp_word);
    checkOutput("miss_count", miss_count, exp_miss);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic readHit(input logic [15:0] addr, input logic [15:0] exp_word);
    applyStimulus(1'b1, 1'b0, addr, 16'h0);
    checkOutput("hit_ready", d_read_ready, 1);
    checkOutput("hit_rdata", d_rdata, exp_word);
    checkOutput("hit_no_memrd", mem_read, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    exp_hits++;
    checkOutput("hit_count", hit_count, exp_hits);
  endtask

  task automatic writeThru(input logic [15:0] addr, input logic [15:0] data);
    int nw;
    int nd;
    applyStimulus(1'b0, 1'b1, addr, data);
    checkOutput("wr_idle_memwr", mem_write, 0);
    checkOutput("wr_idle_done", d_write_done, 0);
    nw = 0;
    nd = 0;
    for (int i = 0; i < 8 && nd == 0; i++) begin
      tick();
      if (mem_write) begin
        nw++;
        checkOutput("wr_mem_addr", mem_addr, addr);
        checkOutput("wr_mem_wdata", mem_wdata, data);
        checkOutput("wr_no_read", mem_read, 0);
      end
      if (d_write_done) nd++;
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    checkOutput("wr_cycles", nw, 2);
    checkOutput("wr_done_pulses", nd, 1);
    tick();
    checkOutput("wr_done_single", d_write_done, 0);
    checkOutput("wr_idle_after", mem_write, 0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_hits   = 0;
    mem_rblock = 64'h0;
    reset_n    = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("rst_ready", d_read_ready, 0);
    checkOutput("rst_done", d_write_done, 0);
    checkOutput("rst_memrd", mem_read, 0);
    checkOutput("rst_memwr", mem_write, 0);
    checkOutput("rst_hits", hit_count, 0);
    checkOutput("rst_misses", miss_count, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    readMiss(16'h0015, 64'h4444_3333_2222_1111, 16'h2222, 16'd1);
    checkOutput("hits_after_miss", hit_count, 0);
    readHit(16'h0017, 16'h4444);

    writeThru(16'h0016, 16'hBEEF);
    readHit(16'h0016, 16'hBEEF);

    writeThru(16'h0100, 16'h1234);
    readMiss(16'h0100, 64'hD4D4_C3C3_B2B2_1234, 16'h1234, 16'd2);

    readMiss(16'h0054, 64'h8888_7777_6666_5555, 16'h5555, 16'd3);
    readMiss(16'h0014, 64'h4444_BEEF_2222_1111, 16'h1111, 16'd4);
    readHit(16'h0016, 16'hBEEF);

    $display("[TB] reset during a fill");
    applyStimulus(1'b1, 1'b0, 16'h0035, 16'h0);
    tick();
    checkOutput("pre_rst_memrd", mem_read, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_memrd", mem_read, 0);
    checkOutput("async_rst_addr", mem_addr, 0);
    checkOutput("async_rst_misses", miss_count, 0);
    checkOutput("async_rst_hits", hit_count, 0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    reset_n = 1'b1;
    tick();
    exp_hits = 0;
    readMiss(16'h0015, 64'h4444_BEEF_2222_1111, 16'h2222, 16'd1);
    readHit(16'h0016, 16'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
